// File: rtl/vga_timing_gen_if.sv
// Pixel/VGA bus between the timing generator and its neighbours.
//   color_px    : 6-bit registered colour from the shape blocks {R1,R0,G1,G0,B1,B0}
//   x_px, y_px  : current pixel and line counters
//   px_tick     : one-clk pulse on each pixel advance
//   active      : undelayed visible-area flag
//   hsync/vsync : sync pins, aligned with rgb
//   rgb         : registered colour to the DAC pins, blanked outside the visible area
//   frame_start : one-clk pulse when the counters enter 0,0
// master = timing generator, slave = consumer (shape blocks / pins).
interface vga_timing_gen_if;
  logic [5:0] color_px;
  logic [9:0] x_px;
  logic [9:0] y_px;
  logic       px_tick;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic [5:0] rgb;
  logic       frame_start;

  modport master (
    input  color_px,
    output x_px, y_px, px_tick, active, hsync, vsync, rgb, frame_start
  );

  modport slave (
    output color_px,
    input  x_px, y_px, px_tick, active, hsync, vsync, rgb, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator. Produces pixel/line counters for the colour blocks, then delays
// sync and blanking by PIPE_DLY clks so they line up with the registered colour coming
// back, and drives hsync/vsync/rgb registered and sample-aligned.
// Ports:
//   clk   : system clock
//   reset : asynchronous reset, active-high
//   vga   : vga_timing_gen_if master (color_px in; counters, syncs, rgb out)
module vga_timing_gen #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned PIPE_DLY = 1,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic               clk,
  input  logic               reset,
  vga_timing_gen_if.master   vga
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [1:0] DIV_MAX  = 2'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic       POL      = 1'(SYNC_POL);
  // Delay-line idle word: {hs, vs, active} = inactive syncs, blanked.
  localparam logic [2:0] DLY_IDLE = {~POL, ~POL, 1'b0};

  logic [1:0] div_q, div_d;
  logic       tick_q;
  logic [9:0] x_q, y_q;
  logic       frame_q;
  logic       hs_raw, vs_raw, act;
  logic [2:0] dly;
  logic       hs_q, vs_q;
  logic [5:0] rgb_q;

  always_comb begin
    div_d  = (div_q == DIV_MAX) ? 2'd0 : div_q + 2'd1;
    act    = (x_q < H_VIS_C) && (y_q < V_VIS_C);
    hs_raw = ((x_q >= HS_START) && (x_q < HS_END)) ? POL : ~POL;
    vs_raw = ((y_q >= VS_START) && (y_q < VS_END)) ? POL : ~POL;
  end

  // tick_q is registered from the next prescaler value, so it is high exactly in the
  // cycles where the prescaler sits at its wrap value, and never during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= 2'd0;
      tick_q  <= 1'b0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      tick_q  <= (div_d == DIV_MAX);
      frame_q <= 1'b0;
      if (tick_q) begin
        if (x_q == H_MAX) begin
          x_q <= 10'd0;
          if (y_q == V_MAX) begin
            y_q     <= 10'd0;
            frame_q <= 1'b1;
          end else begin
            y_q <= y_q + 10'd1;
          end
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

  // Alignment line matching the downstream colour latency.
  if (PIPE_DLY == 0) begin : g_nodly
    assign dly = {hs_raw, vs_raw, act};
  end else begin : g_dly
    logic [2:0] line_q [PIPE_DLY];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(PIPE_DLY); i++) line_q[i] <= DLY_IDLE;
      end else begin
        line_q[0] <= {hs_raw, vs_raw, act};
        for (int i = 1; i < int'(PIPE_DLY); i++) line_q[i] <= line_q[i-1];
      end
    end
    assign dly = line_q[PIPE_DLY-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q  <= ~POL;
      vs_q  <= ~POL;
      rgb_q <= 6'd0;
    end else begin
      hs_q  <= dly[2];
      vs_q  <= dly[1];
      rgb_q <= dly[0] ? vga.color_px : 6'd0;
    end
  end

  assign vga.x_px        = x_q;
  assign vga.y_px        = y_q;
  assign vga.px_tick     = tick_q;
  assign vga.active      = act;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.rgb         = rgb_q;
  assign vga.frame_start = frame_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Drives the pixel-coordinate side of the display pipeline: generates x_px/y_px for the color/shape blocks and the VGA hsync/vsync/RGB pins.
- The shape blocks return a registered 6-bit color; this block delays its sync and blanking signals so they line up with that color.
- It then gates the color to zero outside the visible area.
- Default timing is 640x480 at a 25 MHz pixel rate.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 1, clk cycles per pixel (1..4)
- PIPE_DLY, 1, clk cycles of latency in the downstream color path (0..3)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- color_px  in  6  pixel color returned by shape blocks, {R1,R0,G1,G0,B1,B0}
- x_px  out  10  current horizontal pixel count, 0..H_total-1
- y_px  out  10  current line count, 0..V_total-1
- px_tick  out  1  one-clk pulse on each pixel advance
- active  out  1  (x_px < H_VIS) && (y_px < V_VIS), undelayed
- hsync  out  1  horizontal sync, delay-aligned to rgb
- vsync  out  1  vertical sync, delay-aligned to rgb
- rgb  out  6  registered color to DAC pins, 0 during blanking
- frame_start  out  1  one-clk pulse when x_px=0 and y_px=0 is entered

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high. All flops are reset asynchronously.
- Derived totals: H_total = H_VIS+H_FP+H_SYNC+H_BP (800); V_total = V_VIS+V_FP+V_SYNC+V_BP (525). Both must be ≤ 1024.
- Values during reset:
  - x_px = 0, y_px = 0, prescaler = 0
  - px_tick = 0, frame_start = 0, rgb = 0
  - hsync = vsync = !SYNC_POL (inactive)
  - all delay-line stages hold inactive/blank
- Pixel prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - px_tick = 1 in the cycle the prescaler wraps.
  - For CLK_DIV=1, px_tick = 1 every cycle after reset release.
- Counters:
  - On px_tick, x_px increments.
  - At H_total-1, x_px wraps to 0 and y_px increments.
  - At V_total-1 with x wrap, y_px wraps to 0.
  - x_px and y_px are registered and change only on px_tick.
- frame_start: registered, asserted for exactly one clk in the cycle x_px,y_px become 0,0 (not asserted out of reset).
- Raw sync terms, from the current counters:
  - hs_raw = SYNC_POL when H_VIS+H_FP ≤ x_px < H_VIS+H_FP+H_SYNC, else !SYNC_POL
  - vs_raw = SYNC_POL when V_VIS+V_FP ≤ y_px < V_VIS+V_FP+V_SYNC, else !SYNC_POL
- Alignment delay line:
  - {hs_raw, vs_raw, active} pass through a PIPE_DLY-stage shift register clocked every clk.
  - hsync and vsync are then registered once more.
  - Total latency from counter change to hsync/vsync is PIPE_DLY+1 clk.
- RGB output:
  - rgb <= delayed_active ? color_px : 0, registered.
  - rgb is sample-aligned with hsync/vsync.
  - With PIPE_DLY=1, a shape block's 1-cycle registered color for coordinate (x,y) appears on rgb in the same clk as that coordinate's sync state.
- Mid-frame reset: all state returns to reset values immediately. After release, counting restarts at 0,0 with the prescaler at 0.
- Boundaries:
  - x_px never reaches H_total.
  - y_px changes only together with the x wrap.
  - The last visible pixel is x=639; rgb is forced to 0 from x=640 (delayed) onward, even when color_px ≠ 0.

Test Plan:
- Reset held with color_px=6'h3F → rgb=0, hsync=vsync=1, x_px=y_px=0. Assert reset mid-line at x=300, y=100 → all outputs return to reset values asynchronously, before the next clk edge.
- CLK_DIV=1, defaults, run 800 clks from reset release → x_px sequences 0..799 then 0, y_px=1 after wrap. hsync low for exactly 96 clks, starting PIPE_DLY+1 clks after x_px=656.
- Run a full frame (420000 clks) → vsync low for 2 lines (1600 clks), starting at line 490. frame_start pulses once, 420000 clks apart.
- color_px tied to 6'h2A → rgb=6'h2A only for the delayed positions with x<640, y<480, 0 elsewhere. Count 307200 non-zero rgb samples per frame.
- CLK_DIV=2 → px_tick every 2nd clk, x_px holds for 2 clks per step, line length 1600 clks.
- SYNC_POL=1 → hsync high during x=656..751 (delayed), low otherwise. A 1-cycle-registered shape model over x 101..200 gives rgb non-zero exactly during delayed x 101..200.
